// File: rtl/ram8_clr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram8_clr_pkg : shared sizes and FSM encoding for the ram8_clr bank |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package ram8_clr_pkg;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage : ram8_clr_pkg
`default_nettype wire

// File: rtl/ram8_clr_dmux8way.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram8_clr_dmux8way : routes one strobe to one of eight outputs      |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module ram8_clr_dmux8way
  import ram8_clr_pkg::*;
(
  input  logic              in_i,
  input  logic [ADDR_W-1:0] sel_i,
  output logic [DEPTH-1:0]  out_o
);

  for (genvar k = 0; k < DEPTH; k++) begin : g_out
    assign out_o[k] = in_i & (sel_i == ADDR_W'(k));
  end

endmodule : ram8_clr_dmux8way
`default_nettype wire

// File: rtl/ram8_clr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ram8_clr : 8-entry register bank, registered read with bypass and  |
// |            an 8-cycle clear sequencer.  Revision 1.0               |
// +--------------------------------------------------------------------+
module ram8_clr
  import ram8_clr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              read_en,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic [DEPTH-1:0]  valid,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                out_valid_q;
  logic [DEPTH-1:0]    we;
  logic                busy_w;

  assign busy_w = (state_q == ST_CLEAR);

  ram8_clr_dmux8way u_dmux (
    .in_i  (load & ~busy_w),
    .sel_i (address),
    .out_o (we)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Writes and clears never coincide: the decoder is disabled while busy.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (we[k]) begin
        mem_d[k]   = in;
        valid_d[k] = 1'b1;
      end else if (busy_w && (cnt_q == ADDR_W'(k))) begin
        mem_d[k]   = '0;
        valid_d[k] = 1'b0;
      end
    end
  end

  // Reading the next-state view gives write bypass and clear-to-zero for free.
  always_comb begin
    out_d = out_q;
    if (read_en) out_d = mem_d[address];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      out_q       <= out_d;
      out_valid_q <= read_en;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign valid     = valid_q;
  assign busy      = busy_w;

endmodule : ram8_clr
`default_nettype wire

// File: tb/tb_ram8_clr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ram8_clr : directed vector table plus clear/reset sequences     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_ram8_clr;

  typedef struct {
    logic        ld;
    logic        re;
    logic        cl;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] e_out;
    logic        e_ov;
    logic [7:0]  e_valid;
    logic        e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in = '0;
  logic [2:0]  address = '0;
  logic        load = 1'b0;
  logic        read_en = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] out;
  logic        out_valid;
  logic [7:0]  valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram8_clr #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .address   (address),
    .load      (load),
    .read_en   (read_en),
    .clear     (clear),
    .out       (out),
    .out_valid (out_valid),
    .valid     (valid),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic re, input logic cl,
                      input logic [2:0] a, input logic [15:0] d);
    load = ld; read_en = re; clear = cl; address = a; in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_out, input logic e_ov,
                           input logic [7:0] e_valid, input logic e_busy);
    check({tag, " out"}, 32'(out), 32'(e_out));
    check({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
    check({tag, " valid"}, 32'(valid), 32'(e_valid));
    check({tag, " busy"}, 32'(busy), 32'(e_busy));
  endtask

  function automatic vec_t mkv(logic ld, logic re, logic cl, logic [2:0] a, logic [15:0] d,
                               logic [15:0] e_out, logic e_ov, logic [7:0] e_valid, logic e_busy);
    vec_t v;
    v.ld = ld; v.re = re; v.cl = cl; v.a = a; v.d = d;
    v.e_out = e_out; v.e_ov = e_ov; v.e_valid = e_valid; v.e_busy = e_busy;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int busy_cycles;
    logic [7:0] vexp;

    vecs.push_back(mkv(1, 0, 0, 3'd3, 16'h1234, 16'h0000, 0, 8'h08, 0));
    vecs.push_back(mkv(0, 1, 0, 3'd3, 16'h0000, 16'h1234, 1, 8'h08, 0));
    vexp = 8'h08;
    for (int k = 0; k < 8; k++) begin
      vexp[k] = 1'b1;
      vecs.push_back(mkv(1, 0, 0, 3'(k), 16'hA000 + 16'(k), 16'h1234, 0, vexp, 0));
    end
    for (int k = 0; k < 8; k++)
      vecs.push_back(mkv(0, 1, 0, 3'(k), 16'h0000, 16'hA000 + 16'(k), 1, 8'hFF, 0));
    vecs.push_back(mkv(1, 0, 0, 3'd5, 16'h0001, 16'hA007, 0, 8'hFF, 0));
    vecs.push_back(mkv(1, 1, 0, 3'd5, 16'hBEEF, 16'hBEEF, 1, 8'hFF, 0));
    vecs.push_back(mkv(0, 1, 0, 3'd5, 16'h0000, 16'hBEEF, 1, 8'hFF, 0));
    vecs.push_back(mkv(0, 1, 0, 3'd4, 16'h0000, 16'hA004, 1, 8'hFF, 0));

    #2 rst_n = 1'b0;
    #10;
    check_all("reset", 16'h0000, 0, 8'h00, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].re, vecs[i].cl, vecs[i].a, vecs[i].d);
      check_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_ov, vecs[i].e_valid, vecs[i].e_busy);
    end

    // Clear with all entries valid; dropped load and ignored second clear inside.
    step(0, 0, 1, 3'd0, 16'h0000);
    busy_cycles = busy ? 1 : 0;
    check("clr start valid", 32'(valid), 32'h0000_00FF);
    for (int i = 0; i < 8; i++) begin
      if (i == 1)      step(1, 0, 0, 3'd7, 16'h7777);
      else if (i == 3) step(0, 0, 1, 3'd0, 16'h0000);
      else             step(0, 0, 0, 3'd0, 16'h0000);
      check($sformatf("clr valid%0d", i), 32'(valid), 32'(8'(8'hFF << (i + 1))));
      if (busy) busy_cycles++;
    end
    check("clr busy end", 32'(busy), 32'h0);
    step(0, 0, 0, 3'd0, 16'h0000);
    check("clr no extend", 32'(busy), 32'h0);
    check("clr busy cycles", 32'(busy_cycles), 32'd8);
    step(0, 1, 0, 3'd7, 16'h0000);
    check_all("clr rd7", 16'h0000, 1, 8'h00, 0);

    // Load on the edge that starts the clear, then wiped by the first clear edge.
    step(1, 0, 1, 3'd0, 16'h5555);
    check_all("simul start", 16'h0000, 0, 8'h01, 1);
    step(0, 0, 0, 3'd0, 16'h0000);
    check("simul valid0", 32'(valid), 32'h0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 3'd0, 16'h0000);
    check("simul busy end", 32'(busy), 32'h0);
    step(0, 1, 0, 3'd0, 16'h0000);
    check_all("simul rd0", 16'h0000, 1, 8'h00, 0);

    // Asynchronous reset in the middle of a clear.
    step(1, 0, 0, 3'd7, 16'hABCD);
    step(0, 1, 1, 3'd7, 16'h0000);
    check_all("mid start", 16'hABCD, 1, 8'h80, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3'd7, 16'h0000);
    check_all("mid pre", 16'hABCD, 1, 8'h80, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all("mid reset", 16'h0000, 0, 8'h00, 0);
    #2 rst_n = 1'b1;
    step(0, 0, 1, 3'd0, 16'h0000);
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 3'd0, 16'h0000);
      if (busy) busy_cycles++;
    end
    check("post busy cycles", 32'(busy_cycles), 32'd8);
    step(1, 0, 0, 3'd6, 16'hFFFF);
    step(0, 1, 0, 3'd6, 16'h0000);
    check_all("post rd6", 16'hFFFF, 1, 8'h40, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ram8_clr
`default_nettype wire
